// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shift types,
// forwarding selects, NZCV bit positions and a rotate helper.
package arm_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x,
                                                input logic [4:0] amt);
        logic [2*DATA_W-1:0] w_t;
        w_t = {x, x} >> amt;
        return w_t[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX -> EX/MEM bundle of the execute stage. No stall handshake exists:
// the stage consumes ID/EX every cycle and EX/MEM loads every cycle.
interface exe_stage_if;
    import arm_pkg::*;

    logic              wb_en_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic [3:0]        exe_cmd;
    logic              b;
    logic              s;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_operand;
    logic              imm;
    logic [23:0]       signed_imm;
    logic [3:0]        dest_in;
    logic [1:0]        sel_src1;
    logic [1:0]        sel_src2;
    logic [DATA_W-1:0] mem_fwd_val;
    logic [DATA_W-1:0] wb_fwd_val;

    logic              branch_taken;
    logic [DATA_W-1:0] branch_addr;
    logic [3:0]        status;
    logic              wb_en_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] st_val;
    logic [3:0]        dest_out;

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd, b, s, pc_in,
               val_rn, val_rm, shift_operand, imm, signed_imm, dest_in,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        output branch_taken, branch_addr, status, wb_en_out, mem_r_en_out,
               mem_w_en_out, alu_res, st_val, dest_out
    );

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd, b, s, pc_in,
               val_rn, val_rm, shift_operand, imm, signed_imm, dest_in,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        input  branch_taken, branch_addr, status, wb_en_out, mem_r_en_out,
               mem_w_en_out, alu_res, st_val, dest_out
    );

endinterface

// File: rtl/alu.sv
// Execute-stage ALU: result and NZCV from command, operands and current flags.
// Unknown commands give 0 and pass the current flags through unchanged.
module alu
    import arm_pkg::*;
(
    input  logic [3:0]        i_cmd,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_status,
    output logic [DATA_W-1:0] o_res,
    output logic [3:0]        o_nzcv
);

    logic [DATA_W:0] w_sum;
    logic            w_c;
    logic            w_v;
    logic            w_known;

    always_comb begin
        w_sum   = '0;
        o_res   = '0;
        w_c     = i_status[FLAG_C];
        w_v     = i_status[FLAG_V];
        w_known = 1'b1;
        case (i_cmd)
            CMD_MOV: o_res = i_b;
            CMD_MVN: o_res = ~i_b;
            CMD_ADD, CMD_ADC: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b}
                      + {{DATA_W{1'b0}}, (i_cmd == CMD_ADC) & i_status[FLAG_C]};
                o_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (o_res[DATA_W-1] != i_a[DATA_W-1]);
            end
            CMD_SUB, CMD_SBC: begin
                // a - b - borrow as a + ~b + carry; the carry-out is the not-borrow
                w_sum = {1'b0, i_a} + {1'b0, ~i_b}
                      + {{DATA_W{1'b0}}, (i_cmd == CMD_SUB) | i_status[FLAG_C]};
                o_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (o_res[DATA_W-1] != i_a[DATA_W-1]);
            end
            CMD_AND: o_res = i_a & i_b;
            CMD_ORR: o_res = i_a | i_b;
            CMD_EOR: o_res = i_a ^ i_b;
            default: w_known = 1'b0;
        endcase
        o_nzcv = w_known ? {o_res[DATA_W-1], (o_res == '0), w_c, w_v} : i_status;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 generation, ALU, NZCV status
// register, branch resolution and the EX/MEM pipeline register.
module exe_stage
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    exe_stage_if.slave ex
);

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_rm_fwd;
    logic [DATA_W-1:0] w_val2;
    logic [DATA_W-1:0] w_alu_res;
    logic [3:0]        w_nzcv;
    logic [4:0]        w_shamt;

    logic [3:0]        r_status;
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic              r_mem_w_en;
    logic [DATA_W-1:0] r_alu_res;
    logic [DATA_W-1:0] r_st_val;
    logic [3:0]        r_dest;

    assign w_shamt = ex.shift_operand[11:7];

    always_comb begin
        w_op_a = ex.val_rn;
        case (ex.sel_src1)
            FWD_MEM: w_op_a = ex.mem_fwd_val;
            FWD_WB:  w_op_a = ex.wb_fwd_val;
            default: w_op_a = ex.val_rn;
        endcase

        w_rm_fwd = ex.val_rm;
        case (ex.sel_src2)
            FWD_MEM: w_rm_fwd = ex.mem_fwd_val;
            FWD_WB:  w_rm_fwd = ex.wb_fwd_val;
            default: w_rm_fwd = ex.val_rm;
        endcase

        // Memory offset beats immediate, immediate beats shifted register
        w_val2 = w_rm_fwd;
        if (ex.mem_r_en_in || ex.mem_w_en_in) begin
            w_val2 = {{(DATA_W-12){1'b0}}, ex.shift_operand};
        end else if (ex.imm) begin
            w_val2 = ror32({{(DATA_W-8){1'b0}}, ex.shift_operand[7:0]},
                           {ex.shift_operand[11:8], 1'b0});
        end else begin
            case (ex.shift_operand[6:5])
                SHIFT_LSL: w_val2 = w_rm_fwd << w_shamt;
                SHIFT_LSR: w_val2 = w_rm_fwd >> w_shamt;
                SHIFT_ASR: w_val2 = $signed(w_rm_fwd) >>> w_shamt;
                default:   w_val2 = ror32(w_rm_fwd, w_shamt);
            endcase
        end
    end

    alu u_alu (
        .i_cmd    (ex.exe_cmd),
        .i_a      (w_op_a),
        .i_b      (w_val2),
        .i_status (r_status),
        .o_res    (w_alu_res),
        .o_nzcv   (w_nzcv)
    );

    assign ex.branch_taken = ex.b;
    assign ex.branch_addr  = ex.pc_in + {{6{ex.signed_imm[23]}}, ex.signed_imm, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status   <= '0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_alu_res  <= '0;
            r_st_val   <= '0;
            r_dest     <= '0;
        end else begin
            if (ex.s && !ex.b) begin
                r_status <= w_nzcv;
            end
            r_wb_en    <= ex.wb_en_in;
            r_mem_r_en <= ex.mem_r_en_in;
            r_mem_w_en <= ex.mem_w_en_in;
            r_alu_res  <= w_alu_res;
            r_st_val   <= w_rm_fwd;
            r_dest     <= ex.dest_in;
        end
    end

    assign ex.status       = r_status;
    assign ex.wb_en_out    = r_wb_en;
    assign ex.mem_r_en_out = r_mem_r_en;
    assign ex.mem_w_en_out = r_mem_w_en;
    assign ex.alu_res      = r_alu_res;
    assign ex.st_val       = r_st_val;
    assign ex.dest_out     = r_dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: an arithmetic reference model feeds an
// expected queue checked every cycle, plus hand-computed literal checks.
module tb_exe_stage;
    import arm_pkg::*;

    localparam int W = 75;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exe_stage_if ex();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [3:0]   m_status;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_pick(input logic [1:0] sel, input logic [31:0] r,
                                           input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return r;
    endfunction

    function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                           input logic [11:0] so, input logic [31:0] rm);
        logic [31:0] x;
        int n;
        if (mem) return {20'd0, so};
        if (imm) begin
            x = {24'd0, so[7:0]};
            n = 2 * int'(so[11:8]);
            for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
            return x;
        end
        x = rm;
        n = int'(so[11:7]);
        for (int i = 0; i < n; i++) begin
            case (so[6:5])
                2'b00:   x = {x[30:0], 1'b0};
                2'b01:   x = {1'b0, x[31:1]};
                2'b10:   x = {x[31], x[31:1]};
                default: x = {x[0], x[31:1]};
            endcase
        end
        return x;
    endfunction

    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] st, output logic [31:0] res, output logic [3:0] nzcv);
        longint unsigned ua, uv, us;
        longint sa, sv, sr, lim, k;
        logic c, o, known;
        ua = a; uv = v; sa = $signed(a); sv = $signed(v);
        lim = 64'sd2147483648;
        c = st[1]; o = st[0]; known = 1'b1; res = '0;
        case (cmd)
            4'b0001: res = v;
            4'b1001: res = ~v;
            4'b0010, 4'b0011: begin
                k = (cmd == 4'b0011 && st[1]) ? 1 : 0;
                us = ua + uv + longint'(k);
                res = us[31:0];
                c = (us >= 64'd4294967296);
                sr = sa + sv + k;
                o = (sr >= lim) || (sr < -lim);
            end
            4'b0100, 4'b0101: begin
                k = (cmd == 4'b0101 && !st[1]) ? 1 : 0;
                res = a - v - 32'(k);
                c = (ua >= uv + longint'(k));
                sr = sa - sv - k;
                o = (sr >= lim) || (sr < -lim);
            end
            4'b0110: res = a & v;
            4'b0111: res = a | v;
            4'b1000: res = a ^ v;
            default: known = 1'b0;
        endcase
        nzcv = known ? {res[31], res == 32'd0, c, o} : st;
    endtask

    always @(posedge clk or negedge rst) begin
        logic [31:0] a, rmf, v2, res;
        logic [3:0] nzcv;
        if (!rst) begin
            exp_q.delete();
            m_status = 4'd0;
        end else begin
            a   = m_pick(ex.sel_src1, ex.val_rn, ex.mem_fwd_val, ex.wb_fwd_val);
            rmf = m_pick(ex.sel_src2, ex.val_rm, ex.mem_fwd_val, ex.wb_fwd_val);
            v2  = m_val2(ex.mem_r_en_in | ex.mem_w_en_in, ex.imm, ex.shift_operand, rmf);
            m_alu(ex.exe_cmd, a, v2, m_status, res, nzcv);
            if (ex.s && !ex.b) m_status = nzcv;
            exp_q.push_back({ex.wb_en_in, ex.mem_r_en_in, ex.mem_w_en_in, res, rmf,
                             ex.dest_in, m_status});
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        longint off;
        act = {ex.wb_en_out, ex.mem_r_en_out, ex.mem_w_en_out, ex.alu_res, ex.st_val,
               ex.dest_out, ex.status};
        if (!rst) begin
            check("reset_state", act, '0);
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("exmem_status", act, exp);
        end
        off = $signed(ex.signed_imm);
        check("branch_taken", W'(ex.branch_taken), W'(ex.b));
        check("branch_addr", W'(ex.branch_addr), W'(32'(longint'(ex.pc_in) + off * 4)));
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic s, input logic imm,
                          input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
        ex.exe_cmd = cmd; ex.s = s; ex.imm = imm; ex.shift_operand = so;
        ex.val_rn = rn; ex.val_rm = rm;
        ex.wb_en_in = 1'b1; ex.mem_r_en_in = 1'b0; ex.mem_w_en_in = 1'b0;
        ex.b = 1'b0; ex.pc_in = 32'h0; ex.signed_imm = 24'h0; ex.dest_in = 4'h3;
        ex.sel_src1 = 2'b00; ex.sel_src2 = 2'b00;
        ex.mem_fwd_val = 32'h0; ex.wb_fwd_val = 32'h0;
    endtask

    task automatic idle();
        set_op(4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0);
        ex.wb_en_in = 1'b0;
        ex.dest_in  = 4'h0;
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic        s;
        logic        imm;
        logic        mr;
        logic [11:0] so;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] res;
        logic [3:0]  st;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{4'b0111, 1'b1, 1'b0, 1'b0, 12'h000, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0010};
        tbl[1]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 12'h000, 32'h000000FF, 32'h0000000F, 32'h000000F0, 4'b0010};
        tbl[2]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 12'h000, 32'h000000F0, 32'h0000000F, 32'h00000000, 4'b0110};
        tbl[3]  = '{4'b1001, 1'b0, 1'b1, 1'b0, 12'h000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0110};
        tbl[4]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 12'h000, 32'd10,       32'd3,        32'd7,        4'b0010};
        tbl[5]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 12'h000, 32'd3,        32'd10,       32'hFFFFFFF9, 4'b1000};
        tbl[6]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 12'h000, 32'd10,       32'd3,        32'd6,        4'b1000};
        tbl[7]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 12'h0A0, 32'h0,        32'h80000001, 32'h40000000, 4'b1000};
        tbl[8]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 12'h460, 32'h0,        32'h12345678, 32'h78123456, 4'b1000};
        tbl[9]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 12'hF80, 32'h0,        32'h00000003, 32'h80000000, 4'b1000};
        tbl[10] = '{4'b0001, 1'b0, 1'b0, 1'b0, 12'hFC0, 32'h0,        32'h7FFFFFFF, 32'h00000000, 4'b1000};
        tbl[11] = '{4'b1111, 1'b1, 1'b0, 1'b0, 12'h000, 32'd5,        32'd5,        32'h00000000, 4'b1000};
        tbl[12] = '{4'b0011, 1'b1, 1'b0, 1'b0, 12'h000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        tbl[13] = '{4'b0011, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0,        32'h0,        32'h00000001, 4'b0110};
        tbl[14] = '{4'b0010, 1'b0, 1'b1, 1'b1, 12'hFFF, 32'h00001000, 32'h0,        32'h00001FFF, 4'b0110};

        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_res", W'(ex.alu_res), '0);
        check("rst_status", W'(ex.status), '0);
        rst = 1'b1;

        // Signed overflow on ADD
        set_op(CMD_ADD, 1'b1, 1'b0, 12'h000, 32'h7FFFFFFF, 32'h1);
        step();
        check("add_ovf_res", W'(ex.alu_res), W'(32'h80000000));
        check("add_ovf_nzcv", W'(ex.status), W'(4'b1001));

        set_op(CMD_SUB, 1'b1, 1'b0, 12'h000, 32'd5, 32'd5);
        step();
        check("sub_eq_res", W'(ex.alu_res), W'(32'h0));
        check("sub_eq_nzcv", W'(ex.status), W'(4'b0110));
        set_op(CMD_ADC, 1'b0, 1'b0, 12'h000, 32'd1, 32'd1);
        step();
        check("adc_res", W'(ex.alu_res), W'(32'd3));

        set_op(CMD_MOV, 1'b0, 1'b1, 12'h4FF, 32'h0, 32'h0);
        step();
        check("mov_imm_rot", W'(ex.alu_res), W'(32'hFF000000));
        set_op(CMD_MOV, 1'b0, 1'b0, 12'h240, 32'h0, 32'h80000000);
        step();
        check("mov_asr4", W'(ex.alu_res), W'(32'hF8000000));

        // Taken branch with s=1 must not disturb the flags
        set_op(CMD_SUB, 1'b1, 1'b0, 12'h000, 32'd1, 32'd2);
        ex.b = 1'b1; ex.pc_in = 32'h100; ex.signed_imm = 24'hFFFFFE;
        #1;
        check("br_taken_lit", W'(ex.branch_taken), W'(1'b1));
        check("br_addr_lit", W'(ex.branch_addr), W'(32'hF8));
        step();
        check("br_status_hold", W'(ex.status), W'(4'b0110));

        set_op(CMD_SUB, 1'b0, 1'b0, 12'h000, 32'hDEAD, 32'hBEEF);
        ex.sel_src1 = 2'b01; ex.mem_fwd_val = 32'd10;
        ex.sel_src2 = 2'b10; ex.wb_fwd_val = 32'd3;
        step();
        check("fwd_sub", W'(ex.alu_res), W'(32'd7));

        set_op(CMD_ADD, 1'b0, 1'b0, 12'h004, 32'hDEAD, 32'hBEEF);
        ex.wb_en_in = 1'b0; ex.mem_w_en_in = 1'b1;
        ex.sel_src1 = 2'b01; ex.mem_fwd_val = 32'd10;
        ex.sel_src2 = 2'b10; ex.wb_fwd_val = 32'd3;
        step();
        check("str_addr", W'(ex.alu_res), W'(32'd14));
        check("str_val", W'(ex.st_val), W'(32'd3));
        check("str_ctrl", W'({ex.wb_en_out, ex.mem_w_en_out}), W'(2'b01));

        set_op(CMD_ADD, 1'b0, 1'b0, 12'h000, 32'd20, 32'd22);
        ex.sel_src1 = 2'b11; ex.sel_src2 = 2'b11;
        ex.mem_fwd_val = 32'd100; ex.wb_fwd_val = 32'd200;
        step();
        check("sel11_reg", W'(ex.alu_res), W'(32'd42));

        for (int i = 0; i < 15; i++) begin
            set_op(tbl[i].cmd, tbl[i].s, tbl[i].imm, tbl[i].so, tbl[i].rn, tbl[i].rm);
            if (tbl[i].mr) begin
                ex.mem_r_en_in = 1'b1;
            end
            step();
            check($sformatf("vec%0d_res", i), W'(ex.alu_res), W'(tbl[i].res));
            check($sformatf("vec%0d_nzcv", i), W'(ex.status), W'(tbl[i].st));
        end

        idle();
        step();
        check("bubble", W'({ex.wb_en_out, ex.mem_r_en_out, ex.mem_w_en_out, ex.alu_res}), '0);

        // Asynchronous reset in the middle of an S instruction
        set_op(CMD_ADD, 1'b1, 1'b0, 12'h000, 32'h80000000, 32'h80000000);
        step();
        check("pre_rst_nzcv", W'(ex.status), W'(4'b0111));
        set_op(CMD_SUB, 1'b1, 1'b0, 12'h000, 32'd1, 32'd9);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_status", W'(ex.status), '0);
        check("mid_rst_exmem", W'({ex.wb_en_out, ex.mem_r_en_out, ex.mem_w_en_out,
                                   ex.alu_res, ex.st_val, ex.dest_out}), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_op(CMD_MOV, 1'b0, 1'b0, 12'h000, 32'h0, 32'd5);
        step();
        check("post_rst_res", W'(ex.alu_res), W'(32'd5));
        check("post_rst_nzcv", W'(ex.status), '0);
        set_op(CMD_MOV, 1'b1, 1'b0, 12'h000, 32'h0, 32'd0);
        step();
        check("post_rst_s_nzcv", W'(ex.status), W'(4'b0100));

        idle();
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
